cac_dec_seq: RTL
================

# cac_dec_seq

Sequencing controller for the FNS-based CAC receive path. It accepts one multi-group codeword vector over a valid/ready handshake. It decodes the groups one per cycle through a single shared 5-bit weighted-sum decoder and returns the assembled binary word over a second valid/ready handshake. Group weights 3..5 are runtime-configurable Fibonacci coefficients. The block sits between the bus receiver and the data sink, so the decoder datapath does not need to be replicated per group.

## Interface
Parameters:
- `NGRP`, 4: number of code groups per vector.
- `GW`, 5: bits per code group. Fixed at 5.
- `BLEN`, 8: decoded data width per group.
- `FNSW`, 4: width of each configurable weight.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: input vector valid.
- `in_ready`, out, 1: block can accept a vector.
- `codein`, in, NGRP*GW: code groups; group g is `[g*GW +: GW]`.
- `en_flag`, in, NGRP*GW: per-bit enable mask, aligned with `codein`.
- `cfg_we`, in, 1: weight register write strobe.
- `cfg_addr`, in, 2: 0 selects w2, 1 selects w3, 2 selects w4; 3 is ignored.
- `cfg_wdata`, in, FNSW: weight write data.
- `out_valid`, out, 1: decoded word valid.
- `out_ready`, in, 1: sink accepts the word.
- `dataout`, out, NGRP*BLEN: decoded word; group g is `[g*BLEN +: BLEN]`.
- `err`, out, 1: pattern error flag (see Configuration).
- `busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states and transitions:
  - IDLE → DEC on `in_valid && in_ready`.
  - DEC → DONE after group NGRP-1 is decoded.
  - DONE → IDLE on `out_ready`.
- `in_ready = (state==IDLE) && !rst`.
- On accept, latch `codein & en_flag` into a vector register, set `idx=0`, and clear the result register.
- In DEC, each cycle:
  - m = masked group `idx`.
  - sum = m[0] + m[1] + (m[2]?w2:0) + (m[3]?w3:0) + (m[4]?w4:0), computed at BLEN+2 bits and truncated to BLEN (modulo 2^BLEN).
  - Write sum to result slot `idx`, then `idx++`.
- `dataout` is driven from the result register. It is only meaningful while `out_valid` is high and is stable for the whole DONE state.
- Weight registers reset to w2=2, w3=3, w4=5.
- `cfg_we` takes effect only in IDLE; it is ignored in DEC and DONE.
- Simultaneous cfg write and vector accept in IDLE: the write lands on the same edge, and the new weight applies to that vector.
- Reset at any point, including mid-DEC: the FSM returns to IDLE, the in-flight vector is discarded, and the weights return to their reset values.

## Timing
- Reset values:
  - `in_ready` = 0 during reset, 1 on the first cycle after reset.
  - `out_valid`=0, `dataout`=0, `err`=0, `busy`=0.
- Accept at edge T. Groups 0..NGRP-1 are decoded at edges T+1..T+NGRP. `out_valid` is high from the cycle after edge T+NGRP.
- Latency from accept to `out_valid`: NGRP+1 cycles (5 at default).
- `out_valid` stays asserted, with `dataout` and `err` unchanged, until `out_ready` is high at an edge. `out_valid` drops in the next cycle.
- `in_ready` rises in the cycle after the output handshake; the next accept is possible one cycle later.
- Minimum period per vector: NGRP+2 cycles.
- `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE.

## Configuration
- `CAC_DEC_ERRCHK_EN` defined:
  - During DEC, each masked group is checked for a forbidden CAC pattern: any bit triple [i+2:i], i=0..GW-3, equal to 3'b010 or 3'b101.
  - `err` is sticky across the groups of one vector, cleared on accept, and valid alongside `out_valid`.
  - Decoding is unaffected by the check.
- `CAC_DEC_ERRCHK_EN` not defined: the checker is omitted and `err` is tied to 0.

## Test plan
- Reset, then the default-weights vector below, then `out_ready=1`:
  - `codein={5'b00000,5'b11111,5'b00011,5'b11100}`, `en_flag` all ones, `in_valid` pulse.
  - Required: `out_valid` 5 cycles after accept, `dataout={8'd0,8'd12,8'd2,8'd10}`, `err=0`.
- Mask test: `codein` all ones, `en_flag` group0=5'b00111, others zero → `dataout={0,0,0,8'd4}`.
- Config write w4=15 in IDLE on the same edge as accepting group0=5'b10000 → slot0=15. A write of w4=1 during DEC is ignored, and the next vector still decodes 5'b10000 as 15.
- Backpressure: hold `out_ready=0` for 10 cycles in DONE → `out_valid` stays high, `dataout` is constant, `in_ready=0`. Raise `out_ready` → `in_ready` returns 1 one cycle later.
- Reset asserted mid-DEC (after group 1) → immediately `out_valid=0`, `busy=0`, weights back to 2/3/5. The next vector decodes normally.
- With `CAC_DEC_ERRCHK_EN`: group2=5'b00101 → `err=1`, slot2=3. The following clean vector → `err=0`.

Source files
------------

// File: rtl/cac_dec_seq_if.sv
// Handshake and config bundle for cac_dec_seq: vector in, decoded word out, weight writes.
// master drives the vector/config/out_ready side, slave is the decoder.
interface cac_dec_seq_if #(
  parameter int NGRP = 4,
  parameter int GW   = 5,
  parameter int BLEN = 8,
  parameter int FNSW = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NGRP*GW-1:0]   codein;
  logic [NGRP*GW-1:0]   en_flag;
  logic                 cfg_we;
  logic [1:0]           cfg_addr;
  logic [FNSW-1:0]      cfg_wdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [NGRP*BLEN-1:0] dataout;
  logic                 err;
  logic                 busy;

  modport master (
    output in_valid, codein, en_flag, cfg_we, cfg_addr, cfg_wdata, out_ready,
    input  in_ready, out_valid, dataout, err, busy
  );

  modport slave (
    input  in_valid, codein, en_flag, cfg_we, cfg_addr, cfg_wdata, out_ready,
    output in_ready, out_valid, dataout, err, busy
  );
endinterface

// File: rtl/cac_dec_seq.sv
// CAC receive sequencer: one group per cycle through a shared weighted-sum decoder; accept-to-valid NGRP+1 cycles,
// output held until out_ready, one vector in flight. Optional pattern checker under CAC_DEC_ERRCHK_EN.
module cac_dec_seq #(
  parameter int NGRP = 4,
  parameter int GW   = 5,
  parameter int BLEN = 8,
  parameter int FNSW = 4
) (
  input logic          clk,
  input logic          rst,
  cac_dec_seq_if.slave io
);
  localparam int IW = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic [1:0] {IDLE, DEC, DONE} state_t;

  state_t               state;
  logic [NGRP*GW-1:0]   vec;
  logic [IW-1:0]        idx;
  logic [NGRP*BLEN-1:0] res;
  logic [FNSW-1:0]      w2, w3, w4;
  logic [GW-1:0]        m;
  logic [BLEN-1:0]      sum;

  // Summing directly at BLEN bits gives the same modulo-2^BLEN result as a wider sum truncated.
  always_comb begin
    m   = vec[idx*GW +: GW];
    sum = BLEN'(m[0]) + BLEN'(m[1])
        + (m[2] ? BLEN'(w2) : '0)
        + (m[3] ? BLEN'(w3) : '0)
        + (m[4] ? BLEN'(w4) : '0);
  end

`ifdef CAC_DEC_ERRCHK_EN
  logic bad;
  logic err_q;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i <= GW - 3; i++) begin
      if (m[i +: 3] == 3'b010 || m[i +: 3] == 3'b101) bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == IDLE && io.in_valid) begin
      err_q <= 1'b0;
    end else if (state == DEC) begin
      err_q <= err_q | bad;
    end
  end

  assign io.err = err_q;
`else
  assign io.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      vec   <= '0;
      idx   <= '0;
      res   <= '0;
      w2    <= FNSW'(2);
      w3    <= FNSW'(3);
      w4    <= FNSW'(5);
    end else begin
      case (state)
        IDLE: begin
          // A write landing on the accept edge is visible to that vector, since decoding starts next edge.
          if (io.cfg_we) begin
            case (io.cfg_addr)
              2'd0:    w2 <= io.cfg_wdata;
              2'd1:    w3 <= io.cfg_wdata;
              2'd2:    w4 <= io.cfg_wdata;
              default: ;
            endcase
          end
          if (io.in_valid) begin
            vec   <= io.codein & io.en_flag;
            idx   <= '0;
            res   <= '0;
            state <= DEC;
          end
        end
        DEC: begin
          res[idx*BLEN +: BLEN] <= sum;
          idx <= idx + 1'b1;
          if (idx == IW'(NGRP - 1)) state <= DONE;
        end
        DONE: begin
          if (io.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE) && !rst;
  assign io.out_valid = (state == DONE);
  assign io.busy      = (state != IDLE);
  assign io.dataout   = res;
endmodule
